// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID latch and one-entry skid buffer.
// Optional FETCH_PERF_CNT_EN adds fetch/wait performance counters.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_tgt,
    input  logic [31:0] jump_tgt,
    input  logic [31:0] jr_tgt,
    input  logic        stall,
    input  logic        flush,
    input  logic        halt,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUF    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_inc;
    logic [31:0] redirect_tgt;
    logic        fetch_done;
    logic        take_fetch;
    logic [31:0] skid_instr_p1;
    logic [31:0] skid_npc_p1;

    assign imemREN    = (state == RUN);
    assign imemaddr   = pc;
    assign pc_inc     = pc + PC_STEP;
    assign fetch_done = imemREN & ihit;
    // A returned word survives only if no redirect or halt squashes it this cycle.
    assign take_fetch = fetch_done & (pc_src == 2'd0) & ~halt;

    always_comb begin
        redirect_tgt = pc;
        case (pc_src)
            2'd1:    redirect_tgt = branch_tgt;
            2'd2:    redirect_tgt = jump_tgt;
            2'd3:    redirect_tgt = jr_tgt;
            default: redirect_tgt = pc;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (halt)
                    state_next = HALTED;
                else if (take_fetch && stall && !flush)
                    state_next = BUF;
            end
            BUF: begin
                if (halt)
                    state_next = HALTED;
                else if (!stall || flush)
                    state_next = RUN;
            end
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        pc_next = pc;
        if (state != HALTED && !halt) begin
            if (pc_src != 2'd0)
                pc_next = redirect_tgt;
            else if (fetch_done)
                pc_next = pc_inc;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
            pc    <= PC_INIT;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Skid buffer: captured only on the RUN->BUF edge; fetch is off while full.
    always_ff @(posedge CLK) begin
        if (state == RUN && state_next == BUF) begin
            skid_instr_p1 <= imemload;
            skid_npc_p1   <= pc_inc;
        end
    end

    // IF/ID latch
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            ifid_valid <= 1'b0;
            ifid_instr <= 32'h0;
            ifid_npc   <= 32'h0;
        end else if (stall) begin
            ifid_valid <= ifid_valid;
            ifid_instr <= ifid_instr;
            ifid_npc   <= ifid_npc;
        end else if (state == BUF && !halt) begin
            ifid_valid <= 1'b1;
            ifid_instr <= skid_instr_p1;
            ifid_npc   <= skid_npc_p1;
        end else if (take_fetch) begin
            ifid_valid <= 1'b1;
            ifid_instr <= imemload;
            ifid_npc   <= pc_inc;
        end else begin
            ifid_valid <= 1'b0;
            ifid_instr <= 32'h0;
            ifid_npc   <= 32'h0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_fetched <= 32'h0;
            perf_stall   <= 32'h0;
        end else if (state != HALTED) begin
            if (take_fetch && !flush)
                perf_fetched <= perf_fetched + 32'd1;
            if (imemREN && !ihit)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline latch. It sits directly upstream of the decode/control stage and owns the PC and the instruction-memory request. It captures each returned instruction into the IF/ID register for decode. It honours stall and flush from the hazard unit, and redirects from branch/jump resolution. A one-entry skid buffer preserves an instruction that returns while decode is stalled.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment applied to PC per completed fetch

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
ihit  in  1  instruction memory returns valid imemload this cycle
imemload  in  32  instruction word from memory
imemREN  out  1  instruction read request
imemaddr  out  32  instruction address (equals PC)
pc_src  in  2  redirect select: 0 sequential, 1 branch, 2 jump/jal, 3 jr
branch_tgt  in  32  branch target
jump_tgt  in  32  jump target {npc[31:28], addr26, 2'b00}
jr_tgt  in  32  register target for jr
stall  in  1  hold IF/ID contents (from hazard unit)
flush  in  1  squash IF/ID contents (from hazard unit on redirect)
halt  in  1  halt decoded downstream; stop fetching
ifid_valid  out  1  IF/ID holds a real instruction
ifid_instr  out  32  latched instruction (0 when bubble)
ifid_npc  out  32  PC+PC_STEP of latched instruction

Behaviour:
- Reset (sync, RST=1 at posedge): PC=PC_INIT; state=RUN; buffer empty; ifid_valid=0, ifid_instr=0, ifid_npc=0. RST overrides every other input, including in mid-fetch or HALTED.
- imemaddr=PC combinationally. imemREN=1 only in state RUN; it is 0 in BUF and HALTED.
- fetch_done = imemREN & ihit. Latency is variable. The PC and request hold steady until ihit.
- PC update priority (highest first):
  1. pc_src!=0: PC <= selected target. Any fetch_done in the same cycle is discarded and never latched.
  2. fetch_done & !stall: PC <= PC+PC_STEP.
  3. fetch_done & stall: PC <= PC+PC_STEP, and the instruction goes to the buffer.
  4. Otherwise: hold PC.
  All adds are 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- IF/ID latch priority (highest first):
  1. flush: valid=0, instr=0, npc=0; buffer cleared.
  2. stall: hold all.
  3. buffer full: load buffer contents; buffer cleared.
  4. fetch_done & pc_src==0: valid=1, instr=imemload, npc=PC+PC_STEP.
  5. Otherwise: bubble (valid=0, instr=0, npc=0).
- States:
  - RUN: fetch_done & stall & !flush & pc_src==0 -> BUF (buffer <= {imemload, PC+PC_STEP}).
  - RUN: halt -> HALTED. Halt wins over a concurrent fetch_done; that instruction is discarded and PC holds.
  - BUF: !stall or flush -> RUN.
  - BUF: halt -> HALTED; buffer dropped.
  - HALTED: terminal until RST. imemREN=0. IF/ID drains to bubble on the next non-stalled edge, then stays bubble.
- stall & flush together: flush wins.
- pc_src!=0 while stalled: PC still redirects; IF/ID holds.
- A buffer is never overwritten, since imemREN=0 in BUF.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetched[31:0] and perf_stall[31:0].
  - perf_fetched increments on every fetch_done latched into IF/ID or the buffer.
  - perf_stall increments each cycle imemREN=1 & !ihit.
  - Both counters clear on RST, wrap modulo 2^32, and freeze in HALTED.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then ihit=1 constantly, imemload=0x20010005, pc_src=0 -> cycle after reset imemaddr=0; after 3 edges ifid_npc=0x0000000C, ifid_valid=1, PC=0x0000000C.
- ihit low 3 cycles at PC=0x10 -> imemaddr stays 0x10, ifid_valid=0 for those edges; on ihit edge ifid_instr=imemload, ifid_npc=0x14.
- stall=1 when ihit returns 0xAC220000 at PC=0x20 -> IF/ID unchanged, imemREN=0, PC=0x24; stall drops -> ifid_instr=0xAC220000, ifid_npc=0x24, imemREN=1 next cycle.
- pc_src=1, branch_tgt=0x40, flush=1 coincident with ihit at PC=0x30 -> fetched word discarded, ifid_valid=0, next imemaddr=0x40; pc_src=3, jr_tgt=0x100 -> imemaddr=0x100.
- halt=1 at PC=0x50 -> imemREN=0 from next cycle and PC frozen at 0x50; IF/ID bubble next edge; RST=1 -> PC=0, imemREN=1.
- PC=0xFFFFFFFC with ihit -> ifid_npc=0x00000000 and next imemaddr=0x00000000; with FETCH_PERF_CNT_EN defined, 4 fetches plus 2 wait cycles -> perf_fetched=4, perf_stall=2.
